// File: rtl/ahb_gpio_arb.sv
// ahb_gpio_arb: two-master AHB-lite arbiter sharing the GPIO slave between the core LSU (m0)
// and a secondary requester (m1). A losing address phase is buffered and its master is stalled.
module ahb_gpio_arb #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int RR_EN  = 1
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              m0_hsel_i,
    input  logic              m0_hwrite_i,
    input  logic [2:0]        m0_hsize_i,
    input  logic [2:0]        m0_hburst_i,
    input  logic [1:0]        m0_htrans_i,
    input  logic [AWIDTH-1:0] m0_haddr_i,
    input  logic [DWIDTH-1:0] m0_hwdata_i,
    output logic              m0_hready_o,
    output logic              m0_hresp_o,
    output logic [DWIDTH-1:0] m0_hrdata_o,
    input  logic              m1_hsel_i,
    input  logic              m1_hwrite_i,
    input  logic [2:0]        m1_hsize_i,
    input  logic [2:0]        m1_hburst_i,
    input  logic [1:0]        m1_htrans_i,
    input  logic [AWIDTH-1:0] m1_haddr_i,
    input  logic [DWIDTH-1:0] m1_hwdata_i,
    output logic              m1_hready_o,
    output logic              m1_hresp_o,
    output logic [DWIDTH-1:0] m1_hrdata_o,
    output logic              s_hsel_o,
    output logic              s_hwrite_o,
    output logic [2:0]        s_hsize_o,
    output logic [2:0]        s_hburst_o,
    output logic [1:0]        s_htrans_o,
    output logic [AWIDTH-1:0] s_haddr_o,
    output logic [DWIDTH-1:0] s_hwdata_o,
    output logic              s_hready_o,
    input  logic              s_hreadyout_i,
    input  logic              s_hresp_i,
    input  logic [DWIDTH-1:0] s_hrdata_i
);
    // owner    | meaning
    // OWN_NONE | no data phase in flight
    // OWN_M0   | current data phase belongs to m0
    // OWN_M1   | current data phase belongs to m1
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_M0 = 2'd1, OWN_M1 = 2'd2} owner_t;

    owner_t            r_owner;
    logic              r_last;
    logic [1:0]        r_pend;
    logic [1:0]        r_pwrite;
    logic [2:0]        r_psize  [2];
    logic [2:0]        r_pburst [2];
    logic [AWIDTH-1:0] r_paddr  [2];

    logic [1:0]        w_hsel, w_hwrite, w_own, w_hready, w_req, w_cand, w_gnt;
    logic [2:0]        w_hsize  [2];
    logic [2:0]        w_hburst [2];
    logic [1:0]        w_htrans [2];
    logic [AWIDTH-1:0] w_haddr  [2];
    logic              w_gidx;

    assign w_hsel      = {m1_hsel_i, m0_hsel_i};
    assign w_hwrite    = {m1_hwrite_i, m0_hwrite_i};
    assign w_hsize[0]  = m0_hsize_i;
    assign w_hsize[1]  = m1_hsize_i;
    assign w_hburst[0] = m0_hburst_i;
    assign w_hburst[1] = m1_hburst_i;
    assign w_htrans[0] = m0_htrans_i;
    assign w_htrans[1] = m1_htrans_i;
    assign w_haddr[0]  = m0_haddr_i;
    assign w_haddr[1]  = m1_haddr_i;
    assign w_own       = {r_owner == OWN_M1, r_owner == OWN_M0};

    // A buffered master stays stalled until its own data phase completes.
    always_comb begin
        for (int m = 0; m < 2; m++) begin
            w_hready[m] = r_pend[m] ? 1'b0 : (w_own[m] ? s_hreadyout_i : 1'b1);
            w_req[m]    = w_hsel[m] & w_htrans[m][1] & w_hready[m];
        end
    end

    assign w_cand = (|r_pend) ? r_pend : w_req;

    always_comb begin
        w_gnt = 2'b00;
        if (s_hreadyout_i) begin
            if (&w_cand) begin
                w_gnt = ((RR_EN != 0) && (r_last == 1'b0)) ? 2'b10 : 2'b01;
            end else begin
                w_gnt = w_cand;
            end
        end
    end

    assign w_gidx = w_gnt[1];

    always_comb begin
        s_hsel_o   = 1'b0;
        s_hwrite_o = 1'b0;
        s_hsize_o  = 3'b000;
        s_hburst_o = 3'b000;
        s_htrans_o = 2'b00;
        s_haddr_o  = '0;
        if (|w_gnt) begin
            s_hsel_o = 1'b1;
            if (r_pend[w_gidx]) begin
                s_hwrite_o = r_pwrite[w_gidx];
                s_hsize_o  = r_psize[w_gidx];
                s_hburst_o = r_pburst[w_gidx];
                s_htrans_o = 2'b10;
                s_haddr_o  = r_paddr[w_gidx];
            end else begin
                s_hwrite_o = w_hwrite[w_gidx];
                s_hsize_o  = w_hsize[w_gidx];
                s_hburst_o = w_hburst[w_gidx];
                s_htrans_o = w_htrans[w_gidx];
                s_haddr_o  = w_haddr[w_gidx];
            end
        end
    end

    assign s_hready_o  = s_hreadyout_i;
    assign s_hwdata_o  = w_own[0] ? m0_hwdata_i : (w_own[1] ? m1_hwdata_i : '0);
    assign m0_hready_o = w_hready[0];
    assign m1_hready_o = w_hready[1];
    assign m0_hrdata_o = w_own[0] ? s_hrdata_i : '0;
    assign m1_hrdata_o = w_own[1] ? s_hrdata_i : '0;
    assign m0_hresp_o  = w_own[0] & s_hresp_i;
    assign m1_hresp_o  = w_own[1] & s_hresp_i;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_owner  <= OWN_NONE;
            r_last   <= 1'b1;
            r_pend   <= 2'b00;
            r_pwrite <= 2'b00;
            for (int m = 0; m < 2; m++) begin
                r_psize[m]  <= 3'b000;
                r_pburst[m] <= 3'b000;
                r_paddr[m]  <= '0;
            end
        end else begin
            // A stalled slave extends the current data phase, so ownership holds.
            if (s_hreadyout_i) begin
                if (w_gnt[0]) begin
                    r_owner <= OWN_M0;
                end else if (w_gnt[1]) begin
                    r_owner <= OWN_M1;
                end else begin
                    r_owner <= OWN_NONE;
                end
                if (|w_gnt) begin
                    r_last <= w_gnt[1];
                end
            end
            for (int m = 0; m < 2; m++) begin
                if (w_req[m] && !w_gnt[m]) begin
                    r_pend[m]   <= 1'b1;
                    r_pwrite[m] <= w_hwrite[m];
                    r_psize[m]  <= w_hsize[m];
                    r_pburst[m] <= w_hburst[m];
                    r_paddr[m]  <= w_haddr[m];
                end else if (w_gnt[m]) begin
                    r_pend[m] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ahb_gpio_arb.sv
// Bench for ahb_gpio_arb: directed scenarios on a round-robin and a fixed-priority instance,
// then random AHB traffic on the round-robin instance against a transaction-level model.
module tb_ahb_gpio_arb;
    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] rexp;
        logic        rresp;
    } txn_t;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    always #5 hclk = ~hclk;

    logic        m_hsel [2];
    logic        m_hwrite [2];
    logic [2:0]  m_hsize [2];
    logic [2:0]  m_hburst [2];
    logic [1:0]  m_htrans [2];
    logic [31:0] m_haddr [2];
    logic [31:0] m_hwdata [2];
    logic        s_hreadyout = 1'b1;
    logic        s_hresp = 1'b0;
    logic [31:0] s_hrdata = 32'h0;

    logic        o_m0_hready [2];
    logic        o_m1_hready [2];
    logic        o_m0_hresp [2];
    logic        o_m1_hresp [2];
    logic [31:0] o_m0_hrdata [2];
    logic [31:0] o_m1_hrdata [2];
    logic        o_s_hsel [2];
    logic        o_s_hwrite [2];
    logic        o_s_hready [2];
    logic [2:0]  o_s_hsize [2];
    logic [2:0]  o_s_hburst [2];
    logic [1:0]  o_s_htrans [2];
    logic [31:0] o_s_haddr [2];
    logic [31:0] o_s_hwdata [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ahb_gpio_arb #(.AWIDTH(32), .DWIDTH(32), .RR_EN(g == 0 ? 1 : 0)) u_dut (
            .hclk(hclk), .hresetn(hresetn),
            .m0_hsel_i(m_hsel[0]), .m0_hwrite_i(m_hwrite[0]), .m0_hsize_i(m_hsize[0]),
            .m0_hburst_i(m_hburst[0]), .m0_htrans_i(m_htrans[0]), .m0_haddr_i(m_haddr[0]),
            .m0_hwdata_i(m_hwdata[0]), .m0_hready_o(o_m0_hready[g]), .m0_hresp_o(o_m0_hresp[g]),
            .m0_hrdata_o(o_m0_hrdata[g]),
            .m1_hsel_i(m_hsel[1]), .m1_hwrite_i(m_hwrite[1]), .m1_hsize_i(m_hsize[1]),
            .m1_hburst_i(m_hburst[1]), .m1_htrans_i(m_htrans[1]), .m1_haddr_i(m_haddr[1]),
            .m1_hwdata_i(m_hwdata[1]), .m1_hready_o(o_m1_hready[g]), .m1_hresp_o(o_m1_hresp[g]),
            .m1_hrdata_o(o_m1_hrdata[g]),
            .s_hsel_o(o_s_hsel[g]), .s_hwrite_o(o_s_hwrite[g]), .s_hsize_o(o_s_hsize[g]),
            .s_hburst_o(o_s_hburst[g]), .s_htrans_o(o_s_htrans[g]), .s_haddr_o(o_s_haddr[g]),
            .s_hwdata_o(o_s_hwdata[g]), .s_hready_o(o_s_hready[g]),
            .s_hreadyout_i(s_hreadyout), .s_hresp_i(s_hresp), .s_hrdata_i(s_hrdata)
        );
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    endtask

    function automatic logic [31:0] rdy(int i, int m);
        return 32'(m == 0 ? o_m0_hready[i] : o_m1_hready[i]);
    endfunction
    function automatic logic [31:0] rdat(int i, int m);
        return m == 0 ? o_m0_hrdata[i] : o_m1_hrdata[i];
    endfunction
    function automatic logic [31:0] rsp(int i, int m);
        return 32'(m == 0 ? o_m0_hresp[i] : o_m1_hresp[i]);
    endfunction

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic drv(int m, logic act, logic wr, logic [31:0] addr, logic [31:0] wd);
        m_hsel[m]   = act;
        m_htrans[m] = act ? 2'b10 : 2'b00;
        m_hwrite[m] = wr;
        m_haddr[m]  = addr;
        m_hwdata[m] = wd;
        m_hsize[m]  = 3'd2;
        m_hburst[m] = 3'd0;
    endtask

    // transaction-level model state for the random phase
    txn_t        ap [2];
    txn_t        dp [2];
    txn_t        bl [2];
    txn_t        sdp;
    bit          ap_v [2];
    bit          dp_v [2];
    bit          bl_v [2];
    bit          sdp_v;
    int          sdp_m;
    int          last_srv;
    logic [31:0] ref_mem [128];
    logic [31:0] s_mem [128];

    function automatic bit busy();
        return ap_v[0] | ap_v[1] | dp_v[0] | dp_v[1] | bl_v[0] | bl_v[1] | sdp_v;
    endfunction

    task automatic rnd_cycle(input bit issue);
        logic r;
        logic exp_rdy [2];
        bit   live [2];
        int   gm;
        int   own;
        bit   from_bl;
        txn_t gt;
        @(posedge hclk);
        #1;
        r = ($urandom_range(0, 3) != 0);
        s_hreadyout = r;
        s_hrdata = sdp_v ? s_mem[sdp.addr[8:2]] : $urandom;
        s_hresp  = sdp_v ? sdp.addr[6] : 1'b0;
        for (int m = 0; m < 2; m++) begin
            if (!ap_v[m] && issue && ($urandom_range(0, 1) == 1)) begin
                ap[m].addr  = 32'(m << 8) | 32'($urandom_range(0, 63) << 2);
                ap[m].wr    = 1'($urandom_range(0, 1));
                ap[m].wdata = $urandom;
                ap[m].rexp  = 32'h0;
                ap[m].rresp = ap[m].addr[6];
                ap_v[m] = 1'b1;
            end
            m_hsel[m]   = ap_v[m] ? 1'b1 : 1'($urandom_range(0, 1));
            m_htrans[m] = ap_v[m] ? 2'b10 : 2'b00;
            m_haddr[m]  = ap_v[m] ? ap[m].addr : $urandom;
            m_hwrite[m] = ap_v[m] ? ap[m].wr : 1'($urandom_range(0, 1));
            m_hsize[m]  = 3'd2;
            m_hburst[m] = 3'd0;
            m_hwdata[m] = (dp_v[m] && dp[m].wr) ? dp[m].wdata : $urandom;
        end
        #1;
        own = sdp_v ? sdp_m : -1;
        for (int m = 0; m < 2; m++) begin
            exp_rdy[m] = bl_v[m] ? 1'b0 : ((own == m) ? r : 1'b1);
            check_eq($sformatf("rnd_hready_m%0d", m), rdy(0, m), 32'(exp_rdy[m]));
            live[m] = ap_v[m] && exp_rdy[m];
        end
        // Buffered transfers go first; ties go to whoever was not served last.
        gm = -1;
        from_bl = 1'b0;
        if (r) begin
            if (bl_v[0] || bl_v[1]) begin
                from_bl = 1'b1;
                gm = (bl_v[0] && bl_v[1]) ? (last_srv == 0 ? 1 : 0) : (bl_v[0] ? 0 : 1);
            end else if (live[0] || live[1]) begin
                gm = (live[0] && live[1]) ? (last_srv == 0 ? 1 : 0) : (live[0] ? 0 : 1);
            end
        end
        check_eq("rnd_s_hsel", 32'(o_s_hsel[0]), 32'(gm >= 0));
        if (gm >= 0) begin
            gt = from_bl ? bl[gm] : ap[gm];
            check_eq("rnd_s_haddr", o_s_haddr[0], gt.addr);
            check_eq("rnd_s_hwrite", 32'(o_s_hwrite[0]), 32'(gt.wr));
            check_eq("rnd_s_htrans", 32'(o_s_htrans[0]), 32'd2);
        end else begin
            gt = '0;
            check_eq("rnd_s_htrans_idle", 32'(o_s_htrans[0]), 32'd0);
        end
        for (int m = 0; m < 2; m++) begin
            if (own == m) begin
                if (r && !dp[m].wr) check_eq($sformatf("rnd_hrdata_m%0d", m), rdat(0, m), dp[m].rexp);
                if (r) check_eq($sformatf("rnd_hresp_m%0d", m), rsp(0, m), 32'(dp[m].rresp));
            end else begin
                check_eq($sformatf("rnd_idle_hrdata_m%0d", m), rdat(0, m), 32'h0);
                check_eq($sformatf("rnd_idle_hresp_m%0d", m), rsp(0, m), 32'h0);
            end
        end
        if (sdp_v && sdp.wr) check_eq("rnd_s_hwdata", o_s_hwdata[0], sdp.wdata);
        else if (!sdp_v) check_eq("rnd_s_hwdata_idle", o_s_hwdata[0], 32'h0);

        if (r && sdp_v) begin
            if (sdp.wr) s_mem[sdp.addr[8:2]] = sdp.wdata;
            sdp_v = 1'b0;
        end
        for (int m = 0; m < 2; m++) begin
            if (exp_rdy[m]) begin
                dp_v[m] = 1'b0;
                if (ap_v[m]) begin
                    dp[m] = ap[m];
                    dp[m].rexp = ref_mem[ap[m].addr[8:2]];
                    if (ap[m].wr) ref_mem[ap[m].addr[8:2]] = ap[m].wdata;
                    dp_v[m] = 1'b1;
                    ap_v[m] = 1'b0;
                    if (gm != m || from_bl) begin
                        bl[m] = dp[m];
                        bl_v[m] = 1'b1;
                    end
                end
            end
        end
        if (gm >= 0) begin
            if (from_bl) bl_v[gm] = 1'b0;
            sdp = gt;
            sdp_m = gm;
            sdp_v = 1'b1;
            last_srv = gm;
        end
    endtask

    initial begin
        drv(0, 0, 0, 32'h0, 32'h0);
        drv(1, 0, 0, 32'h0, 32'h0);
        #3;
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_m0_hready", rdy(i, 0), 32'd1);
            check_eq("rst_m1_hready", rdy(i, 1), 32'd1);
            check_eq("rst_s_htrans", 32'(o_s_htrans[i]), 32'd0);
            check_eq("rst_s_hsel", 32'(o_s_hsel[i]), 32'd0);
            check_eq("rst_m0_hrdata", rdat(i, 0), 32'h0);
        end
        @(posedge hclk);
        #1 hresetn = 1'b1;
        s_hrdata = 32'h5;

        // single m0 write: address in the same cycle, data next cycle
        tick();
        drv(0, 1, 1, 32'h4, 32'h0);
        #1;
        check_eq("solo_s_haddr", o_s_haddr[0], 32'h4);
        check_eq("solo_s_hsel", 32'(o_s_hsel[0]), 32'd1);
        check_eq("solo_m0_hready", rdy(0, 0), 32'd1);

        // live collision after an m0 grant: round-robin gives m1, fixed priority gives m0
        tick();
        drv(0, 1, 0, 32'h8, 32'h1);
        drv(1, 1, 0, 32'h100, 32'h0);
        #1;
        check_eq("solo_s_hwdata_rr", o_s_hwdata[0], 32'h1);
        check_eq("solo_s_hwdata_fp", o_s_hwdata[1], 32'h1);
        check_eq("coll_rr_winner", o_s_haddr[0], 32'h100);
        check_eq("coll_fp_winner", o_s_haddr[1], 32'h8);

        tick();
        drv(0, 0, 0, 32'h0, 32'h0);
        drv(1, 0, 0, 32'h0, 32'h0);
        #1;
        check_eq("coll_rr_m0_stall", rdy(0, 0), 32'd0);
        check_eq("coll_rr_buf_addr", o_s_haddr[0], 32'h8);
        check_eq("coll_rr_buf_trans", 32'(o_s_htrans[0]), 32'd2);
        check_eq("read_rr_m1_hrdata", rdat(0, 1), 32'h5);
        check_eq("read_rr_m0_hrdata", rdat(0, 0), 32'h0);
        check_eq("coll_fp_m1_stall", rdy(1, 1), 32'd0);
        check_eq("coll_fp_buf_addr", o_s_haddr[1], 32'h100);
        check_eq("read_fp_m0_hrdata", rdat(1, 0), 32'h5);
        check_eq("read_fp_m1_hrdata", rdat(1, 1), 32'h0);

        tick();
        #1;
        check_eq("buf_rr_m0_ready", rdy(0, 0), 32'd1);
        check_eq("buf_rr_m0_hrdata", rdat(0, 0), 32'h5);
        check_eq("buf_rr_idle", 32'(o_s_hsel[0]), 32'd0);
        check_eq("buf_fp_m1_hrdata", rdat(1, 1), 32'h5);

        // slave stall of three cycles while m1 issues
        tick();
        drv(0, 1, 1, 32'h10, 32'h0);
        #1;
        check_eq("stall_s_haddr", o_s_haddr[0], 32'h10);
        tick();
        drv(0, 0, 0, 32'h0, 32'hAA);
        drv(1, 1, 0, 32'h104, 32'h0);
        s_hreadyout = 1'b0;
        #1;
        check_eq("stall_m0_track", rdy(0, 0), 32'd0);
        check_eq("stall_m1_accept", rdy(0, 1), 32'd1);
        check_eq("stall_no_sel", 32'(o_s_hsel[0]), 32'd0);
        check_eq("stall_hwdata", o_s_hwdata[0], 32'hAA);
        for (int k = 0; k < 2; k++) begin
            tick();
            drv(1, 0, 0, 32'h0, 32'h0);
            #1;
            check_eq("stall_m1_pend", rdy(0, 1), 32'd0);
            check_eq("stall_m0_hold", rdy(0, 0), 32'd0);
            check_eq("stall_htrans", 32'(o_s_htrans[0]), 32'd0);
        end
        tick();
        s_hreadyout = 1'b1;
        #1;
        check_eq("stall_m0_done", rdy(0, 0), 32'd1);
        check_eq("stall_m1_buf_addr", o_s_haddr[0], 32'h104);
        check_eq("stall_m1_still", rdy(0, 1), 32'd0);
        tick();
        #1;
        check_eq("stall_m1_done", rdy(0, 1), 32'd1);
        check_eq("stall_m1_hrdata", rdat(0, 1), 32'h5);

        // collision after m1 was served last: m0 wins; then reset drops the buffered m1
        tick();
        drv(0, 1, 0, 32'h20, 32'h0);
        drv(1, 1, 0, 32'h120, 32'h0);
        #1;
        check_eq("tie_m0_first", o_s_haddr[0], 32'h20);
        tick();
        drv(0, 0, 0, 32'h0, 32'h0);
        drv(1, 0, 0, 32'h0, 32'h0);
        s_hreadyout = 1'b0;
        #1;
        check_eq("tie_m1_stall", rdy(0, 1), 32'd0);
        #1 hresetn = 1'b0;
        #1;
        check_eq("mid_rst_m0_hready", rdy(0, 0), 32'd1);
        check_eq("mid_rst_m1_hready", rdy(0, 1), 32'd1);
        check_eq("mid_rst_htrans", 32'(o_s_htrans[0]), 32'd0);
        check_eq("mid_rst_m0_hrdata", rdat(0, 0), 32'h0);
        check_eq("mid_rst_m1_hrdata", rdat(0, 1), 32'h0);
        tick();
        hresetn = 1'b1;
        s_hreadyout = 1'b1;
        #1;
        check_eq("post_rst_buf_clear", 32'(o_s_hsel[0]), 32'd0);
        check_eq("post_rst_m1_ready", rdy(0, 1), 32'd1);

        // random traffic from a clean reset
        hresetn = 1'b0;
        tick();
        hresetn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ap_v[i] = 1'b0;
            dp_v[i] = 1'b0;
            bl_v[i] = 1'b0;
        end
        sdp_v = 1'b0;
        sdp_m = 0;
        last_srv = 1;
        for (int i = 0; i < 128; i++) begin
            ref_mem[i] = $urandom;
            s_mem[i] = ref_mem[i];
        end
        for (int c = 0; c < 3000; c++) rnd_cycle(1'b1);
        for (int c = 0; c < 200 && busy(); c++) rnd_cycle(1'b0);
        check_eq("drain_idle", 32'(busy()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
